sevenseg_scan_counter: RTL

- Parametrised multiplexed 7-segment display driver with a built-in NUM_DIGITS-digit BCD up/down counter, load, carry output and configurable count and scan rates.
- Sits between the board clock and the display pins as a self-contained counter-display subsystem.
- Supersedes fixed 4-digit, free-running, up-only display logic.

---
 rtl/sevenseg_pkg.sv | 20 ++
 rtl/sevenseg_decoder.sv | 24 ++
 rtl/sevenseg_scan_counter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed 7-segment counter display.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a}.
package sevenseg_pkg;
   localparam int BCD_W = 4;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Selector bits are active-low; idle replicates this bit across all digits.
   localparam logic SEL_IDLE_BIT = 1'b1;
endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes blank.
module sevenseg_decoder
   import sevenseg_pkg::*;
(
   input  logic [BCD_W-1:0] i_digit,
   output logic [7:0]       o_pattern
);
   always_comb begin
      o_pattern = SEG_BLANK;
      case (i_digit)
         4'd0:    o_pattern = SEG_0;
         4'd1:    o_pattern = SEG_1;
         4'd2:    o_pattern = SEG_2;
         4'd3:    o_pattern = SEG_3;
         4'd4:    o_pattern = SEG_4;
         4'd5:    o_pattern = SEG_5;
         4'd6:    o_pattern = SEG_6;
         4'd7:    o_pattern = SEG_7;
         4'd8:    o_pattern = SEG_8;
         4'd9:    o_pattern = SEG_9;
         default: o_pattern = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/sevenseg_scan_counter.sv
// NUM_DIGITS-digit BCD up/down counter with load, carry and multiplexed display scan.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module sevenseg_scan_counter
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int COUNT_DIV  = 50000000,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        up_down,
   input  logic                        load,
   input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
   output logic [BCD_W*NUM_DIGITS-1:0] bcd_value,
   output logic                        carry_out,
   output logic [7:0]                  signal_out,
   output logic [NUM_DIGITS-1:0]       selector
);
   localparam int BW = BCD_W * NUM_DIGITS;
   localparam int CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [CW-1:0]         r_cnt_pre;
   logic [SW-1:0]         r_scan_pre;
   logic [IW-1:0]         r_idx;
   logic [BW-1:0]         r_bcd;
   logic                  r_carry;
   logic [NUM_DIGITS-1:0] r_sel;
   logic [7:0]            r_seg;

   logic                  w_tick;
   logic                  w_wrap;
   logic                  w_scan_wrap;
   logic [BW-1:0]         w_next;
   logic [BW-1:0]         w_load_clamped;
   logic [BCD_W-1:0]      w_digit;
   logic [7:0]            w_pattern;
   logic [7:0]            w_seg_next;

   assign w_tick      = enable && (r_cnt_pre == CW'(COUNT_DIV - 1));
   assign w_scan_wrap = (r_scan_pre == SW'(SCAN_DIV - 1));

   // Ripple carry/borrow across digits; w_wrap survives only if every digit rolled over.
   always_comb begin
      w_next = r_bcd;
      w_wrap = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_wrap) begin
            if (up_down) begin
               if (r_bcd[i*BCD_W +: BCD_W] == 4'd9) begin
                  w_next[i*BCD_W +: BCD_W] = 4'd0;
               end else begin
                  w_next[i*BCD_W +: BCD_W] = r_bcd[i*BCD_W +: BCD_W] + 4'd1;
                  w_wrap = 1'b0;
               end
            end else begin
               if (r_bcd[i*BCD_W +: BCD_W] == 4'd0) begin
                  w_next[i*BCD_W +: BCD_W] = 4'd9;
               end else begin
                  w_next[i*BCD_W +: BCD_W] = r_bcd[i*BCD_W +: BCD_W] - 4'd1;
                  w_wrap = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      w_load_clamped = load_value;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (load_value[i*BCD_W +: BCD_W] > 4'd9) w_load_clamped[i*BCD_W +: BCD_W] = 4'd9;
      end
   end

   always_comb begin
      w_digit = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i == int'(r_idx)) w_digit = r_bcd[i*BCD_W +: BCD_W];
      end
   end

   sevenseg_decoder u_decoder (
      .i_digit   (w_digit),
      .o_pattern (w_pattern)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic w_upper_nonzero;

   // A digit is blank when it and everything above it are zero; digit 0 always shows.
   always_comb begin
      w_upper_nonzero = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= int'(r_idx) && r_bcd[i*BCD_W +: BCD_W] != 4'd0) w_upper_nonzero = 1'b1;
      end
      w_seg_next = ((r_idx != '0) && !w_upper_nonzero) ? SEG_BLANK : w_pattern;
   end
`else
   assign w_seg_next = w_pattern;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt_pre  <= '0;
         r_scan_pre <= '0;
         r_idx      <= '0;
         r_bcd      <= '0;
         r_carry    <= 1'b0;
         r_sel      <= {NUM_DIGITS{SEL_IDLE_BIT}};
         r_seg      <= SEG_BLANK;
      end else begin
         if (load) begin
            r_bcd     <= w_load_clamped;
            r_cnt_pre <= '0;
            r_carry   <= 1'b0;
         end else if (w_tick) begin
            r_bcd     <= w_next;
            r_cnt_pre <= '0;
            r_carry   <= w_wrap;
         end else begin
            r_carry <= 1'b0;
            if (enable) r_cnt_pre <= r_cnt_pre + CW'(1);
         end

         if (w_scan_wrap) begin
            r_scan_pre <= '0;
            r_idx      <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
         end else begin
            r_scan_pre <= r_scan_pre + SW'(1);
         end

         r_sel <= ~(NUM_DIGITS'(1) << r_idx);
         r_seg <= w_seg_next;
      end
   end

   assign bcd_value  = r_bcd;
   assign carry_out  = r_carry;
   assign signal_out = r_seg;
   assign selector   = r_sel;
endmodule
